mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the MIPS datapath; implements MULT, MULTU, DIV, DIVU and owns the HI/LO registers.
- Its hi/lo outputs feed the 32-bit 4:1 write-back select mux (MFHI/MFLO path); mthi/mtlo writes arrive from the register-file read port.
- Control stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; the unit is verified only at 32.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; accepted only when busy=0
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: hi/lo hold the new result
- div_zero  output  1  divisor was zero; valid while done=1
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0, immediately force hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE and counter=0. Reset mid-operation abandons the operation with no partial HI/LO update.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 at edge E0 captures a, b and op, and latches the operand signs for MULT/DIV.
  - Operands are converted to magnitudes for signed ops.
  - Next state is MUL (op[1]=0) or DIV (op[1]=1). busy=1 from E0.
- MUL: one radix-2 shift-add step per cycle at E1..E32. The 64-bit partial product is held internally. Counter is incremented each step; at count 31 the next state is FIX.
- DIV: one restoring shift-subtract step per cycle at E1..E32, producing a quotient and remainder; at count 31 the next state is FIX.
- FIX, at edge E33:
  - Apply sign correction.
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; give the remainder the sign of the dividend (truncation toward zero).
  - Write hi={product[63:32] or remainder} and lo={product[31:0] or quotient}.
  - busy=0 and done=1 for exactly the cycle after E33; return to IDLE.
- Latency: 33 cycles from the start edge to hi/lo update. A new start is accepted in the done cycle.
- Divide by zero (b=0, DIV or DIVU): full 33-cycle latency, hi=a (original value), lo=32'hFFFFFFFF, div_zero=1 with done. div_zero=0 at all other times.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0, no flag.
- Start while busy: ignored; the current operation is unaffected.
- Changes on a, b or op after the start edge have no effect.
- hi_we/lo_we:
  - Effective only when busy=0; hi/lo are updated at the clock edge.
  - Ignored while busy.
  - If start and hi_we/lo_we are both high at the same idle edge, start is accepted and the writes are dropped.
- hi/lo hold their value between operations and throughout a busy period; they are never partially updated.

Test Plan:
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> busy for 33 cycles; done in the cycle after E33; hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT a=-3 (32'hFFFFFFFD), b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. MULT a=-4, b=-6 -> hi=0, lo=32'h00000018.
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
- DIVU a=5, b=0 -> after 33 cycles hi=5, lo=32'hFFFFFFFF, div_zero=1 for the done cycle only, 0 afterwards.
- Start MULTU 6*7, then at cycles 5–10 pulse start with op=DIV, hi_we=1 (wdata=32'hDEADBEEF) and change a/b -> result hi=0, lo=42. Later idle lo_we with wdata=9 -> lo=9. Same-edge start+hi_we -> write dropped.
- Start MULTU 3*3; deassert rst_n at cycle 10 (between edges) -> busy, done, hi and lo all 0 immediately. Release, run DIVU 100/7 -> lo=14, hi=2 after 33 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division; both take
// 32 step cycles plus one sign-fix cycle, so hi/lo update 33 cycles after start.
// Handshake: start is accepted on a rising edge only while busy=0; done pulses
// for exactly one cycle once hi/lo hold the new result, and div_zero is only
// meaningful while done=1.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  // state is left as a named internal signal so checkers can bind to it
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // acc holds {partial product} during MUL and {remainder, quotient} during DIV
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_orig;   // raw dividend, returned in HI on divide-by-zero
  logic               neg_res;  // operand signs differ
  logic               neg_rem;  // dividend was negative
  logic               is_div;

  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_try;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               last_step;

  // operand magnitudes, single step datapaths and final sign correction
  always_comb begin
    a_sgn     = ~op[0] & a[WIDTH-1];
    b_sgn     = ~op[0] & b[WIDTH-1];
    a_mag     = a_sgn ? -a : a;
    b_mag     = b_sgn ? -b : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_try   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    last_step = (cnt == CNT_W'(WIDTH - 1));
  end

  // control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      a_orig   <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // start wins over a same-edge MTHI/MTLO write
            opb     <= b_mag;
            a_orig  <= a;
            neg_res <= a_sgn ^ b_sgn;
            neg_rem <= a_sgn;
            is_div  <= op[1];
            acc     <= {{WIDTH{1'b0}}, a_mag};
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= op[1] ? DIV : MUL;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (last_step) state <= FIX;
        end
        DIV: begin
          // keep the shifted remainder when the trial subtraction goes negative
          acc <= div_try[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {div_try[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          cnt <= cnt + 1'b1;
          if (last_step) state <= FIX;
        end
        FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (is_div && (opb == '0)) begin
            hi       <= a_orig;
            lo       <= '1;
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed corner cases plus randomized operations
// compared against an arithmetic reference model through an expected queue.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // expected {div_zero, hi, lo} per issued operation
  logic [64:0] exp_q[$];
  logic [31:0] hi_m, lo_m;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // reference: plain 64-bit arithmetic, SV division truncates toward zero
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'({32'b0, a}) / longint'({32'b0, b});
          r = longint'({32'b0, a}) % longint'({32'b0, b});
        end
        p = {r[31:0], q[31:0]};
      end
    endcase
    return {1'b0, p};
  endfunction

  // issue one operation and follow it to done; returns in the done cycle
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit disturb, input bit same_we);
    logic [64:0] exp;
    int cycles;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    if (same_we) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 2'($urandom_range(0, 3));
    check("busy_e0", 64'(busy), 64'd1);
    check("hi_hold_e0", 64'(hi), 64'(hi_m));
    check("lo_hold_e0", 64'(lo), 64'(lo_m));
    cycles = 0;
    while (!done && cycles < 40) begin
      if (disturb && cycles >= 5 && cycles <= 10) begin
        start = 1'b1; op_i = 2'd2; hi_we = 1'b1; wdata = 32'hDEADBEEF;
        a_i = $urandom; b_i = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (!done && cycles == 20) begin
        check("busy_mid", 64'(busy), 64'd1);
        check("hi_hold_mid", 64'(hi), 64'(hi_m));
        check("lo_hold_mid", 64'(lo), 64'(lo_m));
      end
    end
    start = 1'b0; hi_we = 1'b0;
    check("latency", 64'(cycles), 64'd33);
    exp = exp_q.pop_front();
    check("hi", 64'(hi), 64'(exp[63:32]));
    check("lo", 64'(lo), 64'(exp[31:0]));
    check("div_zero", 64'(div_zero), 64'(exp[64]));
    check("busy_done", 64'(busy), 64'd0);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  task automatic idle_tail();
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("div_zero_clr", 64'(div_zero), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic mt_write(input bit h, input bit l, input logic [31:0] d);
    @(negedge clk);
    hi_we = h; lo_we = l; wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (h) hi_m = d;
    if (l) lo_m = d;
    check("mt_hi", 64'(hi), 64'(hi_m));
    check("mt_lo", 64'(lo), 64'(lo_m));
  endtask

  // main sequence
  initial begin
    rst_n = 1'b0; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    idle_tail();
    do_op(2'd0, 32'hFFFFFFFD, 32'd5, 0, 0);
    do_op(2'd0, 32'hFFFFFFFC, 32'hFFFFFFFA, 0, 0); // started in the done cycle
    idle_tail();
    do_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
    do_op(2'd3, 32'd7, 32'd2, 0, 0);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    idle_tail();
    do_op(2'd3, 32'd5, 32'd0, 0, 0);
    idle_tail();
    do_op(2'd2, 32'hFFFFFFF0, 32'd0, 0, 0);
    idle_tail();
    do_op(2'd1, 32'd6, 32'd7, 1, 0);
    check("disturb_lo", 64'(lo), 64'd42);
    idle_tail();
    mt_write(0, 1, 32'd9);
    mt_write(1, 0, 32'h12345678);
    do_op(2'd1, 32'd2, 32'd3, 0, 1);
    idle_tail();

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      do_op(2'($urandom_range(0, 3)), ra, rb, 0, 0);
      if ($urandom_range(0, 1) == 1) idle_tail();
      if ($urandom_range(0, 3) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
    end
    idle_tail();

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op_i = 2'd1; a_i = 32'd3; b_i = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk); rst_n = 1'b1;
    do_op(2'd3, 32'd100, 32'd7, 0, 0);
    check("divu_100_7_lo", 64'(lo), 64'd14);
    idle_tail();

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
